// File: rtl/uart_rx_cfg_if.sv
// rtl/uart_rx_cfg_if.sv - serial input, config and received-word bus of the configurable UART receiver
interface uart_rx_cfg_if #(
  parameter int DBIT_MAX = 8
);
  logic                rx;
  logic                s_tick;
  logic [3:0]          cfg_dbits;
  logic [1:0]          cfg_parity;
  logic                cfg_stop2;
  logic [DBIT_MAX-1:0] dout;
  logic                rx_done_tick;
  logic                parity_err;
  logic                frame_err;
  logic                busy;

  modport master (
    output rx, s_tick, cfg_dbits, cfg_parity, cfg_stop2,
    input  dout, rx_done_tick, parity_err, frame_err, busy
  );

  modport slave (
    input  rx, s_tick, cfg_dbits, cfg_parity, cfg_stop2,
    output dout, rx_done_tick, parity_err, frame_err, busy
  );
endinterface

// File: rtl/uart_rx_cfg.sv
// rtl/uart_rx_cfg.sv - runtime-configurable oversampling UART receiver (5..DBIT_MAX data, parity, 1/2 stop)
// Optional build macro UART_RX_MAJORITY_EN: 3-sample majority vote at every sampling point.
module uart_rx_cfg #(
  parameter int DBIT_MAX = 8,
  parameter int OS_TICK  = 16
) (
  input  logic          clk,
  input  logic          reset,
  uart_rx_cfg_if.slave  bus
);
  localparam int SW = $clog2(OS_TICK);
  localparam int NW = $clog2(DBIT_MAX);
  localparam logic [SW-1:0] S_MID = SW'(OS_TICK / 2 - 1);
  localparam logic [SW-1:0] S_END = SW'(OS_TICK - 1);
  localparam logic [3:0]    DMAX  = 4'(DBIT_MAX);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  state_t              state, state_n;
  logic [SW-1:0]       s, s_n;
  logic [NW-1:0]       n, n_n;
  logic [DBIT_MAX-1:0] sr, sr_n;
  logic                par, par_n;
  logic                second, second_n;
  logic                perr_p, perr_p_n;
  logic                ferr_p, ferr_p_n;
  logic [3:0]          dbits_r, dbits_n;
  logic [1:0]          parity_r, parity_n;
  logic                stop2_r, stop2_n;
  logic [DBIT_MAX-1:0] dout_r, dout_n;
  logic                perr_r, perr_n;
  logic                ferr_r, ferr_n;
  logic                done_r, done_n;
  logic                samp;
  logic [3:0]          dbits_eff;
  logic                par_en;
  logic                par_odd;

`ifdef UART_RX_MAJORITY_EN
  // The third vote is the value being captured on this very tick.
  logic [1:0] hist;
  always_ff @(posedge clk) begin
    if (!reset)          hist <= 2'b11;
    else if (bus.s_tick) hist <= {hist[0], bus.rx};
  end
  assign samp = (hist[1] & hist[0]) | (hist[1] & bus.rx) | (hist[0] & bus.rx);
`else
  assign samp = bus.rx;
`endif

  assign dbits_eff = (bus.cfg_dbits < 4'd5 || bus.cfg_dbits > DMAX) ? DMAX : bus.cfg_dbits;
  assign par_en    = (parity_r == 2'b01) || (parity_r == 2'b10);
  assign par_odd   = (parity_r == 2'b10);

  always_ff @(posedge clk) begin
    if (!reset) begin
      state    <= IDLE;
      s        <= '0;
      n        <= '0;
      sr       <= '0;
      par      <= 1'b0;
      second   <= 1'b0;
      perr_p   <= 1'b0;
      ferr_p   <= 1'b0;
      dbits_r  <= DMAX;
      parity_r <= 2'b00;
      stop2_r  <= 1'b0;
      dout_r   <= '0;
      perr_r   <= 1'b0;
      ferr_r   <= 1'b0;
      done_r   <= 1'b0;
    end else begin
      state    <= state_n;
      s        <= s_n;
      n        <= n_n;
      sr       <= sr_n;
      par      <= par_n;
      second   <= second_n;
      perr_p   <= perr_p_n;
      ferr_p   <= ferr_p_n;
      dbits_r  <= dbits_n;
      parity_r <= parity_n;
      stop2_r  <= stop2_n;
      dout_r   <= dout_n;
      perr_r   <= perr_n;
      ferr_r   <= ferr_n;
      done_r   <= done_n;
    end
  end

  always_comb begin
    state_n  = state;
    s_n      = s;
    n_n      = n;
    sr_n     = sr;
    par_n    = par;
    second_n = second;
    perr_p_n = perr_p;
    ferr_p_n = ferr_p;
    dbits_n  = dbits_r;
    parity_n = parity_r;
    stop2_n  = stop2_r;
    dout_n   = dout_r;
    perr_n   = perr_r;
    ferr_n   = ferr_r;
    done_n   = 1'b0;
    case (state)
      IDLE: begin
        dbits_n  = dbits_eff;
        parity_n = bus.cfg_parity;
        stop2_n  = bus.cfg_stop2;
        if (!bus.rx) begin
          state_n = START;
          s_n     = '0;
        end
      end
      START: begin
        if (bus.s_tick) begin
          if (s == S_MID) begin
            if (samp) begin
              state_n = IDLE;
            end else begin
              state_n = DATA;
              s_n     = '0;
              n_n     = '0;
              par_n   = 1'b0;
            end
          end else begin
            s_n = s + 1'b1;
          end
        end
      end
      DATA: begin
        if (bus.s_tick) begin
          if (s == S_END) begin
            s_n   = '0;
            sr_n  = {samp, sr[DBIT_MAX-1:1]};
            par_n = par ^ samp;
            if (n == NW'(dbits_r - 4'd1)) begin
              state_n  = par_en ? PARITY : STOP;
              second_n = 1'b0;
              perr_p_n = 1'b0;
              ferr_p_n = 1'b0;
            end else begin
              n_n = n + 1'b1;
            end
          end else begin
            s_n = s + 1'b1;
          end
        end
      end
      PARITY: begin
        if (bus.s_tick) begin
          if (s == S_END) begin
            s_n      = '0;
            perr_p_n = ((samp ^ par) != par_odd);
            state_n  = STOP;
          end else begin
            s_n = s + 1'b1;
          end
        end
      end
      STOP: begin
        if (bus.s_tick) begin
          if (s == S_END) begin
            s_n = '0;
            if (!samp) ferr_p_n = 1'b1;
            if (stop2_r && !second) begin
              second_n = 1'b1;
            end else begin
              // Leaving at the stop-bit centre lets a back-to-back start bit be seen.
              state_n = IDLE;
              done_n  = 1'b1;
              dout_n  = sr >> (DMAX - dbits_r);
              perr_n  = perr_p;
              ferr_n  = ferr_p | ~samp;
            end
          end else begin
            s_n = s + 1'b1;
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

  assign bus.dout         = dout_r;
  assign bus.rx_done_tick = done_r;
  assign bus.parity_err   = perr_r;
  assign bus.frame_err    = ferr_r;
  assign bus.busy         = (state != IDLE);
endmodule

// File: tb/tb_uart_rx_cfg.sv
// tb/tb_uart_rx_cfg.sv - directed self-checking bench for uart_rx_cfg
module tb_uart_rx_cfg;
  logic clk = 1'b0;
  logic reset = 1'b0;
  int   checks = 0;
  int   errors = 0;
  int   div = 0;
  int   done_cnt = 0;
  int   base = 0;
  logic [7:0] log_dout [0:31];

  always #5 clk = ~clk;

  uart_rx_cfg_if #(.DBIT_MAX(8)) bus ();
  uart_rx_cfg #(.DBIT_MAX(8), .OS_TICK(16)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // One s_tick every fourth clock.
  always @(posedge clk) begin
    div        <= (div + 1) % 4;
    bus.s_tick <= (div == 2);
  end

  always @(negedge clk) begin
    if (bus.rx_done_tick === 1'b1) begin
      if (done_cnt < 32) log_dout[done_cnt] = bus.dout;
      done_cnt = done_cnt + 1;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks = checks + 1;
    assert (obs === exp) else begin
      errors = errors + 1;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic hold(input logic lvl, input int nticks);
    bus.rx = lvl;
    repeat (nticks) begin
      @(negedge clk);
      while (bus.s_tick !== 1'b1) @(negedge clk);
      @(negedge clk);
    end
  endtask

  task automatic set_cfg(input logic [3:0] db, input logic [1:0] par, input logic st2);
    bus.cfg_dbits  = db;
    bus.cfg_parity = par;
    bus.cfg_stop2  = st2;
  endtask

  task automatic send(input logic [7:0] d, input int nb, input bit has_par, input bit pbit,
                      input int nstop, input bit stop_low);
    hold(1'b0, 16);
    for (int i = 0; i < nb; i++) hold(d[i], 16);
    if (has_par) hold(pbit, 16);
    for (int i = 0; i < nstop - 1; i++) hold(1'b1, 16);
    if (stop_low) begin
      hold(1'b0, 10);
      hold(1'b1, 16);
    end else begin
      hold(1'b1, 16);
    end
  endtask

  initial begin
    bus.rx     = 1'b1;
    bus.s_tick = 1'b0;
    set_cfg(4'd8, 2'b00, 1'b0);
    repeat (3) @(negedge clk);
    check("rst_dout", 32'(bus.dout), 32'h0);
    check("rst_done", 32'(bus.rx_done_tick), 32'h0);
    check("rst_perr", 32'(bus.parity_err), 32'h0);
    check("rst_ferr", 32'(bus.frame_err), 32'h0);
    check("rst_busy", 32'(bus.busy), 32'h0);
    reset = 1'b1;
    hold(1'b1, 4);

    // 8N1 0xA5
    base = done_cnt;
    send(8'hA5, 8, 1'b0, 1'b0, 1, 1'b0);
    check("8n1_cnt", 32'(done_cnt), 32'(base + 1));
    check("8n1_dout", 32'(bus.dout), 32'hA5);
    check("8n1_perr", 32'(bus.parity_err), 32'h0);
    check("8n1_ferr", 32'(bus.frame_err), 32'h0);
    check("8n1_busy", 32'(bus.busy), 32'h0);

    // 7E2 0x41, good then bad parity
    set_cfg(4'd7, 2'b01, 1'b1);
    send(8'h41, 7, 1'b1, 1'b0, 2, 1'b0);
    check("7e2_dout", 32'(bus.dout), 32'h41);
    check("7e2_perr", 32'(bus.parity_err), 32'h0);
    send(8'h41, 7, 1'b1, 1'b1, 2, 1'b0);
    check("7e2_bad_dout", 32'(bus.dout), 32'h41);
    check("7e2_bad_perr", 32'(bus.parity_err), 32'h1);
    check("7e2_bad_ferr", 32'(bus.frame_err), 32'h0);

    // 5O1 0x1F, good then low stop bit
    set_cfg(4'd5, 2'b10, 1'b0);
    send(8'h1F, 5, 1'b1, 1'b0, 1, 1'b0);
    check("5o1_dout", 32'(bus.dout), 32'h1F);
    check("5o1_perr", 32'(bus.parity_err), 32'h0);
    check("5o1_ferr", 32'(bus.frame_err), 32'h0);
    base = done_cnt;
    send(8'h1F, 5, 1'b1, 1'b0, 1, 1'b1);
    check("5o1_fe_cnt", 32'(done_cnt), 32'(base + 1));
    check("5o1_fe_ferr", 32'(bus.frame_err), 32'h1);
    check("5o1_fe_dout", 32'(bus.dout), 32'h1F);
    check("5o1_fe_busy", 32'(bus.busy), 32'h0);

    // false start: 4 ticks low
    base = done_cnt;
    hold(1'b0, 4);
    hold(1'b1, 20);
    check("glitch_cnt", 32'(done_cnt), 32'(base));
    check("glitch_busy", 32'(bus.busy), 32'h0);
    check("glitch_ferr", 32'(bus.frame_err), 32'h1);
    check("glitch_dout", 32'(bus.dout), 32'h1F);

`ifdef UART_RX_MAJORITY_EN
    set_cfg(4'd8, 2'b00, 1'b0);
    hold(1'b0, 16);
    hold(1'b1, 7);
    hold(1'b0, 1);
    hold(1'b1, 8);
    for (int i = 1; i < 8; i++) hold(1'b1, 16);
    hold(1'b1, 16);
    check("maj_dout", 32'(bus.dout), 32'hFF);
`endif

    // reset after 3rd data bit
    set_cfg(4'd8, 2'b00, 1'b0);
    base = done_cnt;
    hold(1'b0, 16);
    hold(1'b1, 16);
    hold(1'b0, 16);
    hold(1'b1, 16);
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    hold(1'b1, 20);
    check("rst_mid_cnt", 32'(done_cnt), 32'(base));
    check("rst_mid_dout", 32'(bus.dout), 32'h0);
    check("rst_mid_ferr", 32'(bus.frame_err), 32'h0);
    check("rst_mid_busy", 32'(bus.busy), 32'h0);
    send(8'h3C, 8, 1'b0, 1'b0, 1, 1'b0);
    check("after_rst_cnt", 32'(done_cnt), 32'(base + 1));
    check("after_rst_dout", 32'(bus.dout), 32'h3C);

    // back-to-back 8N1 frames
    base = done_cnt;
    send(8'h01, 8, 1'b0, 1'b0, 1, 1'b0);
    send(8'h80, 8, 1'b0, 1'b0, 1, 1'b0);
    check("b2b_cnt", 32'(done_cnt), 32'(base + 2));
    check("b2b_first", 32'(log_dout[base]), 32'h01);
    check("b2b_second", 32'(log_dout[base+1]), 32'h80);
    check("b2b_ferr", 32'(bus.frame_err), 32'h0);
    check("b2b_busy", 32'(bus.busy), 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
